// File: rtl/motor_cmd_sequencer.sv
// Purpose : omni-wheel motor command sequencer; maps 4-bit move codes to per-motor
//           direction pairs, inserts coast dead-time on reversal, drives duty-cycle PWM.
// Latency : dir follows an accepted command 1 cycle later, or DEAD_CYC+1 cycles later
//           when any motor reverses; a new duty takes effect at the next PWM wrap.
// Backpressure: cmd_ready is low only during the dead-time; offered commands are held off.
//
// Optional feature: define MOTOR_WATCHDOG_EN to enable the command watchdog
// (drops to IDLE after WD_CYC cycles in RUN without an accepted command).
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   cmd_valid  command valid
//   cmd_ready  command ready (accept = cmd_valid & cmd_ready)
//   cmd_move   4-bit movement code (pattern table index)
//   cmd_duty   requested PWM duty
//   dir        per motor {in1,in0}: 01 fwd, 10 rev, 00 coast
//   pwm        per motor PWM enable
//   busy       high while coasting through dead-time
//   wd_trip    sticky watchdog flag (tied 0 without MOTOR_WATCHDOG_EN)

module motor_cmd_sequencer #(
    parameter int N_MOTORS = 4,
    parameter int PWM_W    = 8,
    parameter int DEAD_CYC = 16,
    parameter int WD_CYC   = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_move,
    input  logic [PWM_W-1:0]      cmd_duty,
    output logic [2*N_MOTORS-1:0] dir,
    output logic [N_MOTORS-1:0]   pwm,
    output logic                  busy,
    output logic                  wd_trip
);

    // Only the table slots actually driven by some motor take part in reversal detection.
    localparam int N_SLOTS = (N_MOTORS < 4) ? N_MOTORS : 4;
    localparam int DC_W    = $clog2(DEAD_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [7:0]            r_active_pat;
    logic [7:0]            r_pend_pat;
    logic [PWM_W-1:0]      r_pend_duty;
    logic [PWM_W-1:0]      r_shadow_duty;
    logic [PWM_W-1:0]      r_active_duty;
    logic [PWM_W-1:0]      r_cnt;
    logic [DC_W-1:0]       r_dead_cnt;

    logic                  w_accept;
    logic [7:0]            w_new_pat;
    logic                  w_reversal;
    logic                  w_dead_done;
    logic                  w_wrap;
    logic                  w_wd_expire;
    logic [2*N_MOTORS-1:0] w_dir;
    logic [N_MOTORS-1:0]   w_pwm;

    // Move code -> 8-bit pattern, two bits per table slot. Code F is idle.
    function automatic logic [7:0] f_pattern(input logic [3:0] code);
        logic [7:0] pat;
        case (code)
            4'h0:    pat = 8'h00;
            4'h1:    pat = 8'h55;
            4'h2:    pat = 8'hAA;
            4'h3:    pat = 8'h69;
            4'h4:    pat = 8'h96;
            4'h5:    pat = 8'h41;
            4'h6:    pat = 8'h28;
            4'h7:    pat = 8'h82;
            4'h8:    pat = 8'h14;
            4'h9:    pat = 8'h11;
            4'hA:    pat = 8'h44;
            4'hB:    pat = 8'h05;
            4'hC:    pat = 8'h0A;
            4'hD:    pat = 8'h99;
            4'hE:    pat = 8'h66;
            default: pat = 8'h00;
        endcase
        return pat;
    endfunction

    assign cmd_ready   = (r_state != S_DEAD);
    assign busy        = (r_state == S_DEAD);
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_new_pat   = f_pattern(cmd_move);
    assign w_dead_done = (r_state == S_DEAD) && (r_dead_cnt == '0);
    assign w_wrap      = (r_cnt == '1);

    // A reversal is a motor going directly between fwd and rev; starting from or
    // stopping to coast needs no dead-time.
    always_comb begin
        w_reversal = 1'b0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if ((r_active_pat[2*k +: 2] != 2'b00) &&
                (w_new_pat[2*k +: 2] != 2'b00) &&
                (r_active_pat[2*k +: 2] != w_new_pat[2*k +: 2])) begin
                w_reversal = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_RUN: begin
                if (w_accept) begin
                    if (w_reversal) begin
                        w_state_nxt = S_DEAD;
                    end else if (w_new_pat == 8'h00) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end else if (w_wd_expire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DEAD: begin
                // A pending pattern always has a driven motor, so DEAD exits to RUN.
                if (w_dead_done) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Pattern / duty / dead-time datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active_pat  <= '0;
            r_pend_pat    <= '0;
            r_pend_duty   <= '0;
            r_shadow_duty <= '0;
            r_active_duty <= '0;
            r_cnt         <= '0;
            r_dead_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;

            // Duty only changes at the period boundary so no PWM pulse is ever truncated.
            if (w_wrap) begin
                r_active_duty <= r_shadow_duty;
            end

            if (w_accept && !w_reversal) begin
                r_active_pat  <= w_new_pat;
                r_shadow_duty <= cmd_duty;
            end else if (w_accept) begin
                r_pend_pat  <= w_new_pat;
                r_pend_duty <= cmd_duty;
                // Counts DEAD_CYC-1 down to 0: exactly DEAD_CYC cycles in DEAD.
                r_dead_cnt  <= DC_W'(DEAD_CYC - 1);
            end else if (w_dead_done) begin
                r_active_pat  <= r_pend_pat;
                r_shadow_duty <= r_pend_duty;
            end else if (w_wd_expire) begin
                // Motors are coasting after a trip; clear so the next command needs no dead-time.
                r_active_pat <= '0;
            end

            if ((r_state == S_DEAD) && (r_dead_cnt != '0)) begin
                r_dead_cnt <= r_dead_cnt - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: dir is forced to coast outside RUN, pwm is gated by dir.
    // ------------------------------------------------------------------
    always_comb begin
        w_dir = '0;
        w_pwm = '0;
        for (int i = 0; i < N_MOTORS; i++) begin
            if (r_state == S_RUN) begin
                w_dir[2*i +: 2] = r_active_pat[2*(i%4) +: 2];
            end
            w_pwm[i] = (r_cnt < r_active_duty) && (w_dir[2*i +: 2] != 2'b00);
        end
    end

    assign dir = w_dir;
    assign pwm = w_pwm;

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef MOTOR_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYC + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_wd_trip;

    // The counter holds at WD_CYC-1, which means WD_CYC cycles have passed since
    // the last accept. An accept in the same cycle takes priority over the trip.
    assign w_wd_expire = (r_state == S_RUN) && !w_accept &&
                         (r_wd_cnt == WD_W'(WD_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt  <= '0;
            r_wd_trip <= 1'b0;
        end else if (w_accept) begin
            r_wd_cnt  <= '0;
            r_wd_trip <= 1'b0;
        end else begin
            if (r_wd_cnt != WD_W'(WD_CYC - 1)) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_wd_expire) begin
                r_wd_trip <= 1'b1;
            end
        end
    end

    assign wd_trip = r_wd_trip;
`else
    assign w_wd_expire = 1'b0;
    assign wd_trip     = 1'b0;
`endif

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Bench for motor_cmd_sequencer (N_MOTORS=4, PWM_W=8, DEAD_CYC=16, WD_CYC=100).
// Expected dir transitions (value + cycles after the latest accept) are queued by
// the stimulus; an independent monitor pops one entry per observed dir change.

module tb_motor_cmd_sequencer;

    localparam int N  = 4;
    localparam int PW = 8;
    localparam int DC = 16;
    localparam int WD = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_move = 4'h0;
    logic [PW-1:0] cmd_duty = '0;
    logic [2*N-1:0] dir;
    logic [N-1:0]  pwm;
    logic          busy;
    logic          wd_trip;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] dir;
        int         delay;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    motor_cmd_sequencer #(
        .N_MOTORS (N),
        .PWM_W    (PW),
        .DEAD_CYC (DC),
        .WD_CYC   (WD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_move  (cmd_move),
        .cmd_duty  (cmd_duty),
        .dir       (dir),
        .pwm       (pwm),
        .busy      (busy),
        .wd_trip   (wd_trip)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input int dly);
        exp_t e;
        e.dir   = d;
        e.delay = dly;
        exp_q.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Monitor: one scoreboard entry per dir change, latency measured from
    // the most recent accepted handshake.
    // ------------------------------------------------------------------
    logic [7:0] mon_prev = '0;
    int         mon_since = 0;
    exp_t       mon_e;

    always @(negedge clk) begin
        mon_since++;
        if (dir !== mon_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL dir_unexpected: got %0h after %0d cycles, required no change from %0h",
                         dir, mon_since, mon_prev);
            end else begin
                mon_e = exp_q.pop_front();
                check("dir_value", 32'(dir), 32'(mon_e.dir));
                check("dir_latency", mon_since, mon_e.delay);
            end
            mon_prev = dir;
        end
        if (cmd_valid && cmd_ready) mon_since = 0;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send(input logic [3:0] mv, input logic [PW-1:0] dt, output int waited);
        waited = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_move  = mv;
        cmd_duty  = dt;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (cmd_ready !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got no cmd_ready in %0d cycles, required ready", waited);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic count_pwm(input int cycles, output int highs);
        highs = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (pwm == 4'hF) highs++;
        end
    endtask

    task automatic wait_rise(output bit ok);
        logic prev;
        ok = 1'b0;
        @(negedge clk);
        prev = pwm[0];
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            if (!prev && pwm[0]) ok = 1'b1;
            prev = pwm[0];
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL pwm_rise_timeout: got no rising pwm edge, required one");
        end
    endtask

    // Called on the first high cycle; returns the length of the high run.
    task automatic high_run(output int len);
        len = 1;
        @(negedge clk);
        while (pwm[0] && len < 400) begin
            len++;
            @(negedge clk);
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    int w;
    int cnt_a;
    int cnt_b;
    int len;
    bit ok;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dir", 32'(dir), 32'h0);
        check("rst_pwm", 32'(pwm), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(cmd_ready), 32'h1);
        check("rst_wd_trip", 32'(wd_trip), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef MOTOR_WATCHDOG_EN
        // Forward, then silence: trip WD+1 cycles after the accept.
        push_exp(8'h55, 1);
        push_exp(8'h00, WD + 1);
        send(4'h1, 8'h80, w);
        repeat (WD + 10) @(negedge clk);
        check("wd_trip_set", 32'(wd_trip), 32'h1);
        check("wd_dir_coast", 32'(dir), 32'h0);
        check("wd_pwm_off", 32'(pwm), 32'h0);
        // Reverse pattern from IDLE: no dead-time, trip flag clears.
        push_exp(8'hAA, 1);
        send(4'h2, 8'h80, w);
        @(negedge clk);
        check("wd_trip_clear", 32'(wd_trip), 32'h0);
        check("wd_busy", 32'(busy), 32'h0);
        repeat (5) @(negedge clk);
`else
        // 1. IDLE -> forward, half duty.
        push_exp(8'h55, 1);
        send(4'h1, 8'h80, w);
        @(negedge clk);
        check("t1_busy", 32'(busy), 32'h0);
        repeat (300) @(negedge clk);
        count_pwm(256, cnt_a);
        check("t1_pwm_128", cnt_a, 128);

        // 2. forward -> reverse: 16 coast cycles with ready low.
        push_exp(8'h00, 1);
        push_exp(8'hAA, DC + 1);
        send(4'h2, 8'h80, w);
        cnt_a = 0;
        cnt_b = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) cnt_a++;
            if (!cmd_ready) cnt_b++;
        end
        check("t2_busy_cycles", cnt_a, DC);
        check("t2_notready_cycles", cnt_b, DC);

        // 3. Command held during DEAD is taken on the first ready cycle.
        push_exp(8'h00, 1);
        push_exp(8'h55, DC + 1);
        send(4'h1, 8'h80, w);
        push_exp(8'h00, 1);
        push_exp(8'h99, DC + 1);
        send(4'hD, 8'h80, w);
        check("t3_held_cycles", w, DC - 1);
        repeat (25) @(negedge clk);

        // 4. Same move, duty 40h; switch to C0h mid-pulse.
        send(4'hD, 8'h40, w);
        check("t4_same_move_nowait", w, 0);
        repeat (300) @(negedge clk);
        wait_rise(ok);
        fork
            high_run(len);
            begin
                repeat (10) @(posedge clk);
                #1;
                cmd_valid = 1'b1;
                cmd_move  = 4'hD;
                cmd_duty  = 8'hC0;
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
            end
        join
        check("t4_old_period_64", len, 64);
        wait_rise(ok);
        high_run(len);
        check("t4_new_period_192", len, 192);

        // 5. Duty extremes.
        send(4'hD, 8'h00, w);
        repeat (300) @(negedge clk);
        count_pwm(256, cnt_a);
        check("t5_duty_00", cnt_a, 0);
        send(4'hD, 8'hFF, w);
        repeat (300) @(negedge clk);
        count_pwm(256, cnt_a);
        check("t5_duty_ff", cnt_a, 255);

        // 6. Idle code, then a fresh pattern from IDLE needs no dead-time.
        push_exp(8'h00, 1);
        send(4'hF, 8'h80, w);
        @(negedge clk);
        check("t6_idle_ready", 32'(cmd_ready), 32'h1);
        check("t6_idle_busy", 32'(busy), 32'h0);
        push_exp(8'hAA, 1);
        send(4'h2, 8'h80, w);
        check("t6_idle_nowait", w, 0);
        repeat (5) @(negedge clk);

        // 7. Reset during DEAD discards the pending pattern.
        push_exp(8'h00, 1);
        send(4'h1, 8'h80, w);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("t7_rst_dir", 32'(dir), 32'h0);
        check("t7_rst_ready", 32'(cmd_ready), 32'h1);
        check("t7_rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("t7_pending_dropped", 32'(dir), 32'h0);
        push_exp(8'hAA, 1);
        send(4'h2, 8'h80, w);
        repeat (5) @(negedge clk);
        check("t7_after_rst_busy", 32'(busy), 32'h0);
        check("nowd_trip_low", 32'(wd_trip), 32'h0);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no end of test, required completion");
        $fatal(1, "timeout");
    end

endmodule
